// File: rtl/therm_step_decoder.sv
// Binary-to-thermometer decoder for a 7-segment unary DAC. The output slews one
// segment per clock toward each newly accepted code, then holds for a
// programmable settle time and pulses done on the return to idle.
module therm_step_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [6:0] therm_out,
    output logic [2:0] cur_code,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StSettle
    } state_e;

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e           state_q;
    logic [2:0]       target_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       cur_q;
    logic [6:0]       therm_q;
    logic             busy_q;
    logic             done_q;

    // Ready is purely a function of state so upstream sees it in the same cycle.
    assign code_ready = (state_q == StIdle);
    assign therm_out  = therm_q;
    assign cur_code   = cur_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Control FSM with registered outputs; therm_q is shifted rather than
    // re-decoded so exactly one segment toggles per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            target_q <= 3'd0;
            cnt_q    <= '0;
            cur_q    <= 3'd0;
            therm_q  <= 7'b0000000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (code_valid) begin
                        target_q <= code_in;
                        busy_q   <= 1'b1;
                        if (code_in != cur_q) begin
                            state_q <= StStep;
                        end else begin
                            state_q <= StSettle;
                            cnt_q   <= SettleLoad;
                        end
                    end
                end
                StStep: begin
                    if (target_q > cur_q) begin
                        // Rising: light the next segment above the current top.
                        cur_q   <= cur_q + 3'd1;
                        therm_q <= {therm_q[5:0], 1'b1};
                        if (cur_q + 3'd1 == target_q) begin
                            state_q <= StSettle;
                            cnt_q   <= SettleLoad;
                        end
                    end else begin
                        // Falling: extinguish the current top segment.
                        cur_q   <= cur_q - 3'd1;
                        therm_q <= {1'b0, therm_q[6:1]};
                        if (cur_q - 3'd1 == target_q) begin
                            state_q <= StSettle;
                            cnt_q   <= SettleLoad;
                        end
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_therm_step_decoder.sv
// Directed bench for therm_step_decoder: a vector table of target codes with
// hand-computed done latencies, plus hand-written back-pressure, reset and
// sweep sequences, and a per-edge invariant checker.
module tb_therm_step_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [2:0] code_in = 3'd0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [6:0] therm_out;
    logic [2:0] cur_code;
    logic       busy;
    logic       done;

    logic [2:0] code_in2 = 3'd0;
    logic       code_valid2 = 1'b0;
    logic       code_ready2;
    logic [6:0] therm2;
    logic [2:0] cur2;
    logic       busy2;
    logic       done2;

    int n_vec = 0;
    int n_err = 0;
    int mcur [2];
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    therm_step_decoder #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .therm_out  (therm_out),
        .cur_code   (cur_code),
        .busy       (busy),
        .done       (done)
    );

    therm_step_decoder #(.SETTLE_CYCLES(1), .CNT_W(8)) dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in2),
        .code_valid (code_valid2),
        .code_ready (code_ready2),
        .therm_out  (therm2),
        .cur_code   (cur2),
        .busy       (busy2),
        .done       (done2)
    );

    typedef struct {
        logic [2:0] code;
        int         lat;
        logic [6:0] fin;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] therm_of(input int c);
        logic [7:0] v;
        v = (8'd1 << c) - 8'd1;
        return v[6:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic [2:0] c, input logic v);
        if (sel == 0) begin
            code_in    = c;
            code_valid = v;
        end else begin
            code_in2    = c;
            code_valid2 = v;
        end
    endtask

    // Accept one code and follow it edge by edge until the done pulse.
    task automatic run_vec(input int sel, input logic [2:0] code, input int lat,
                           input logic [6:0] fin);
        int start;
        int d;
        int k;
        logic [2:0] expc;
        start = mcur[sel];
        d = (int'(code) > start) ? int'(code) - start : start - int'(code);
        check("ready_before_accept", (sel == 0) ? code_ready : code_ready2, 1);
        drive(sel, code, 1'b1);
        tick();
        drive(sel, code, 1'b0);
        check("cur_at_accept", (sel == 0) ? cur_code : cur2, start);
        check("busy_at_accept", (sel == 0) ? busy : busy2, 1);
        for (int n = 1; n <= lat; n++) begin
            tick();
            k = (n < d) ? n : d;
            expc = (int'(code) > start) ? 3'(start + k) : 3'(start - k);
            check("cur_step", (sel == 0) ? cur_code : cur2, expc);
            check("therm_step", (sel == 0) ? therm_out : therm2, therm_of(int'(expc)));
            check("busy_step", (sel == 0) ? busy : busy2, (n < lat) ? 1 : 0);
            check("done_step", (sel == 0) ? done : done2, (n == lat) ? 1 : 0);
        end
        check("therm_final", (sel == 0) ? therm_out : therm2, fin);
        mcur[sel] = int'(code);
    endtask

    // Per-edge invariants: legal thermometer, one toggle, unit step.
    logic [6:0] pt1, pt2;
    logic [2:0] pc1, pc2;
    int dd1, dd2;
    always @(posedge clk) begin
        #1;
        if (rst_n && chk_on) begin
            dd1 = int'(cur_code) - int'(pc1);
            dd2 = int'(cur2) - int'(pc2);
            check("chk_therm_match", therm_out, therm_of(int'(cur_code)));
            check("chk_one_toggle", ($countones(therm_out ^ pt1) <= 1) ? 1 : 0, 1);
            check("chk_unit_step", (dd1 >= -1 && dd1 <= 1) ? 1 : 0, 1);
            check("chk_fast_therm_match", therm2, therm_of(int'(cur2)));
            check("chk_fast_one_toggle", ($countones(therm2 ^ pt2) <= 1) ? 1 : 0, 1);
            check("chk_fast_unit_step", (dd2 >= -1 && dd2 <= 1) ? 1 : 0, 1);
        end
        pt1 = therm_out;
        pc1 = cur_code;
        pt2 = therm2;
        pc2 = cur2;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{code: 3'd5, lat: 9,  fin: 7'b0011111};
        vecs[1] = '{code: 3'd7, lat: 6,  fin: 7'b1111111};
        vecs[2] = '{code: 3'd2, lat: 9,  fin: 7'b0000011};
        vecs[3] = '{code: 3'd3, lat: 5,  fin: 7'b0000111};
        vecs[4] = '{code: 3'd3, lat: 4,  fin: 7'b0000111};
        vecs[5] = '{code: 3'd0, lat: 7,  fin: 7'b0000000};
        vecs[6] = '{code: 3'd0, lat: 4,  fin: 7'b0000000};
        vecs[7] = '{code: 3'd6, lat: 10, fin: 7'b0111111};
        mcur[0] = 0;
        mcur[1] = 0;

        // Reset state, with a valid code presented during reset.
        code_valid = 1'b1;
        code_in    = 3'd6;
        tick();
        tick();
        check("rst_therm", therm_out, 7'b0000000);
        check("rst_cur", cur_code, 3'd0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", code_ready, 1);
        code_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_cur", cur_code, 3'd0);
        chk_on = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(0, vecs[i].code, vecs[i].lat, vecs[i].fin);
        end

        // Valid held high with changing codes while busy: 6 -> 1 takes 9 edges.
        drive(0, 3'd1, 1'b1);
        tick();
        for (int n = 1; n <= 9; n++) begin
            code_in = (n % 2 == 1) ? 3'd7 : 3'd0;
            tick();
            check("bp_ready", code_ready, (n == 9) ? 1 : 0);
            check("bp_cur", cur_code, (n < 5) ? 6 - n : 1);
            check("bp_done", done, (n == 9) ? 1 : 0);
        end
        code_in = 3'd3;
        tick();
        check("bp_capture_hold", cur_code, 3'd1);
        check("bp_capture_busy", busy, 1);
        check("bp_capture_done", done, 0);
        code_valid = 1'b0;
        tick();
        check("bp_step1", cur_code, 3'd2);
        tick();
        check("bp_step2", therm_out, 7'b0000111);
        for (int n = 1; n <= 4; n++) begin
            tick();
            check("bp_settle_done", done, (n == 4) ? 1 : 0);
        end
        mcur[0] = 3;

        // Reset mid-step: 3 -> 7, interrupted at cur_code = 4.
        drive(0, 3'd7, 1'b1);
        tick();
        drive(0, 3'd7, 1'b0);
        tick();
        check("mid_cur", cur_code, 3'd4);
        check("mid_therm", therm_out, 7'b0001111);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_therm", therm_out, 7'b0000000);
        check("arst_cur", cur_code, 3'd0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", code_ready, 1);
        for (int n = 0; n < 2; n++) begin
            tick();
            check("arst_hold_done", done, 0);
            check("arst_hold_cur", cur_code, 3'd0);
        end
        #2;
        rst_n = 1'b1;
        mcur[0] = 0;
        mcur[1] = 0;
        run_vec(0, 3'd1, 5, 7'b0000001);

        // Fast instance: unit steps 0..7, then one long fall 7 -> 0.
        for (int c = 1; c <= 7; c++) begin
            run_vec(1, 3'(c), 2, therm_of(c));
        end
        run_vec(1, 3'd0, 8, 7'b0000000);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
